// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount arbiter: FSM state encoding and
// default word/result widths used by the top level and the bit-count core.
package popcount_pkg;

    // Default request word width and the matching result width. The result
    // must be able to hold WIDTH itself (all-ones word), hence WIDTH+1.
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CW    = $clog2(DEF_WIDTH + 1);

    // Arbiter FSM states. Only one word is in flight at a time:
    // IDLE  - waiting for a request, readies may be granted
    // COUNT - registered word is being counted (exactly one cycle)
    // DONE  - result held on res_* until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : popcount_pkg

// File: rtl/popcount_core.sv
// Purely combinational population count. Sums the set bits of data_i into a
// CW-bit result; CW is wide enough for an all-ones word, so no overflow.
module popcount_core
    import popcount_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    // Ripple sum over all bits; synthesis folds this into an adder tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule : popcount_core

// File: rtl/popcount_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared popcount
// unit. A granted word is registered, counted in one cycle, and the result is
// held on res_* until the consumer takes it.
//
// Handshake rule (all three interfaces): a transfer happens on a rising edge
// where valid and ready are both high; ready never depends on ready of the
// same interface, and a producer must hold valid/data until the transfer.
module popcount_arbiter
    import popcount_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [CW-1:0]    res_count,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    // Index of the requester granted most recently; a tie goes to the other.
    logic             last_q, last_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             id_q, id_d;
    logic [CW-1:0]    res_count_q, res_count_d;
    logic             res_id_q, res_id_d;

    logic             grant_valid;
    logic             grant_id;
    logic [CW-1:0]    pop_count;

    // Single shared counter, always looking at the registered word.
    popcount_core #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_core (
        .data_i  (word_q),
        .count_o (pop_count)
    );

    // Grant decision: only in IDLE and never while reset is asserted, so at
    // most one ready can be high and both are low everywhere else.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_q;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
            req0_ready = grant_valid && !grant_id;
            req1_ready = grant_valid &&  grant_id;
        end
    end

    // Next-state logic: capture on grant, count for one cycle, hold result.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        word_d      = word_q;
        id_d        = id_q;
        res_count_d = res_count_q;
        res_id_d    = res_id_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    word_d  = grant_id ? req1_data : req0_data;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                res_count_d = pop_count;
                res_id_d    = id_q;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight word and makes requester 0
    // the winner of the first tie by pretending requester 1 went last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            word_q      <= '0;
            id_q        <= 1'b0;
            res_count_q <= '0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            word_q      <= word_d;
            id_q        <= id_d;
            res_count_q <= res_count_d;
            res_id_q    <= res_id_d;
        end
    end

    // Result and status outputs come straight from registered state.
    always_comb begin
        res_valid = (state_q == DONE);
        res_count = res_count_q;
        res_id    = res_id_q;
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

endmodule : popcount_arbiter

// File: tb/tb_popcount_arbiter.sv
// Bench for popcount_arbiter: directed scenarios with a scoreboard queue of
// expected {id, count} pairs, popped when the consumer accepts a result.
module tb_popcount_arbiter;

    localparam int WIDTH = 16;
    localparam int CW    = 5;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [CW-1:0]    res_count;
    logic             busy;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [CW:0] exp_q[$];
    logic        tb_last;   // model of the last granted requester

    popcount_arbiter #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_count  (res_count),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: mutual exclusion of readies and result ordering
    always @(negedge clk) begin
        checks++;
        if (req0_ready && req1_ready) begin
            failures++;
            $display("FAIL ready_exclusive: req0_ready=%b req1_ready=%b, required not both high", req0_ready, req1_ready);
        end
        if (!rst && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got id=%0d count=%0d with nothing expected", res_id, res_count);
            end else begin
                logic [CW:0] exp;
                exp = exp_q.pop_front();
                if ({res_id, res_count} !== exp) begin
                    failures++;
                    $display("FAIL result: got id=%0d count=%0d, required id=%0d count=%0d",
                             res_id, res_count, exp[CW], exp[CW-1:0]);
                end
            end
        end
    end

    task automatic test_reset;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (res_count !== '0) begin failures++; $display("FAIL reset_res_count: got %0d, required 0", res_count); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL reset_res_id: got %0d, required 0", res_id); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tb_last = 1'b1;
        step();
    endtask

    task automatic test_single;
        req0_valid = 1'b1;
        req0_data  = 16'hFFFF;
        res_ready  = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready: got %b%b, required r0=1 r1=0", req0_ready, req1_ready); end
        exp_q.push_back({1'b0, CW'($countones(req0_data))});
        tb_last = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_count_phase: got res_valid=%b busy=%b, required 0/1", res_valid, busy); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_res_valid: got %b, required 1", res_valid); end
        checks++; if (res_count !== 5'b10000 || res_id !== 1'b0) begin failures++; $display("FAIL single_all_ones: got id=%0d count=%0d, required id=0 count=16", res_id, res_count); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL single_return_idle: got busy=%b res_valid=%b, required 0/0", busy, res_valid); end
    endtask

    task automatic test_alternate;
        int   grants;
        logic exp_g;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tb_last = 1'b1;
        req0_data  = 16'h000F;
        req1_data  = 16'h00FF;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        grants = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                exp_g = ~tb_last;
                checks++;
                if (req1_ready !== exp_g || req0_ready !== ~exp_g) begin
                    failures++;
                    $display("FAIL alt_grant: grant %0d got r0=%b r1=%b, required requester %0d", grants, req0_ready, req1_ready, exp_g);
                end
                exp_q.push_back({exp_g, CW'($countones(exp_g ? req1_data : req0_data))});
                tb_last = exp_g;
                grants++;
            end
            @(posedge clk); #1;
        end
        checks++; if (grants != 4) begin failures++; $display("FAIL alt_grant_count: got %0d grants, required 4", grants); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL alt_drain: %0d results outstanding, required 0", exp_q.size()); end
        step();
    endtask

    task automatic test_stall;
        req1_valid = 1'b1;
        req1_data  = 16'h0000;
        res_ready  = 1'b0;
        @(negedge clk);
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL stall_grant: got r0=%b r1=%b, required r0=0 r1=1", req0_ready, req1_ready); end
        exp_q.push_back({1'b1, CW'($countones(req1_data))});
        tb_last = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req0_data  = 16'hFFFF;
        req1_data  = 16'hFFFF;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL stall_count_ready: got %b%b, required 00", req0_ready, req1_ready); end
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_count !== 5'd0 || res_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d got res_valid=%b count=%0d id=%0d readies=%b%b, required 1/0/1/00",
                         c, res_valid, res_count, res_id, req0_ready, req1_ready);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL stall_release: got busy=%b outstanding=%0d, required 0/0", busy, exp_q.size()); end
        step();
    endtask

    task automatic test_sample_once;
        req0_valid = 1'b1;
        req0_data  = 16'hA5A5;
        res_ready  = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL sample_grant: got r0=%b, required 1", req0_ready); end
        exp_q.push_back({1'b0, 5'd8});
        tb_last = 1'b0;
        @(posedge clk); #1;
        req0_data  = 16'hFFFF;
        req0_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sample_drain: %0d results outstanding, required 0", exp_q.size()); end
        step();
    endtask

    task automatic test_reset_in_done;
        req0_valid = 1'b1;
        req0_data  = 16'h1234;
        res_ready  = 1'b0;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rstdone_grant: got r0=%b, required 1", req0_ready); end
        tb_last = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL rstdone_in_done: got res_valid=%b, required 1", res_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tb_last = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstdone_cleared: got res_valid=%b busy=%b, required 0/0", res_valid, busy); end
        checks++; if (res_count !== '0 || res_id !== 1'b0) begin failures++; $display("FAIL rstdone_result_reg: got id=%0d count=%0d, required 0/0", res_id, res_count); end
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 16'hFFFF;
        res_ready  = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rstdone_tie: got r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready); end
        exp_q.push_back({1'b0, CW'($countones(req0_data))});
        tb_last = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rstdone_drain: %0d results outstanding, required 0", exp_q.size()); end
        step();
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        res_ready  = 1'b0;
        tb_last    = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_sample_once();
        test_reset_in_done();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue: %0d results outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_popcount_arbiter
